// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing controller and its pixel source:
// default 640x480@60 timing, RGB565 colour constants and a colour-bar helper.
package vga_pkg;

  localparam int DATA_W = 16;

  typedef logic [DATA_W-1:0] rgb565_t;

  // 640x480 @ 60 Hz, 25 MHz pixel clock
  localparam logic [9:0] H_SYNC_DEF  = 10'd96;
  localparam logic [9:0] H_BACK_DEF  = 10'd48;
  localparam logic [9:0] H_VALID_DEF = 10'd640;
  localparam logic [9:0] H_FRONT_DEF = 10'd16;
  localparam logic [9:0] V_SYNC_DEF  = 10'd2;
  localparam logic [9:0] V_BACK_DEF  = 10'd33;
  localparam logic [9:0] V_VALID_DEF = 10'd480;
  localparam logic [9:0] V_FRONT_DEF = 10'd10;

  // Coordinate value meaning "no pixel requested"
  localparam logic [9:0] PIX_IDLE = 10'h3FF;

  // RGB565 colour constants
  localparam rgb565_t RED    = 16'hF800;
  localparam rgb565_t ORANGE = 16'hFC00;
  localparam rgb565_t YELLOW = 16'hFFE0;
  localparam rgb565_t GREEN  = 16'h07E0;
  localparam rgb565_t CYAN   = 16'h07FF;
  localparam rgb565_t BLUE   = 16'h001F;
  localparam rgb565_t PURPPLE_UNUSED_GUARD = 16'hF81F;
  localparam rgb565_t BLACK  = 16'h0000;
  localparam rgb565_t WHITE  = 16'hFFFF;
  localparam rgb565_t GRAY   = 16'hD69A;

  // Ten 64-pixel-wide vertical bars across a 640-pixel line; anything
  // outside the active line (including PIX_IDLE) maps to black.
  function automatic rgb565_t colour_bar(input logic [9:0] x);
    rgb565_t c;
    case (x[9:6])
      4'd0:    c = RED;
      4'd1:    c = ORANGE;
      4'd2:    c = YELLOW;
      4'd3:    c = GREEN;
      4'd4:    c = CYAN;
      4'd5:    c = BLUE;
      4'd6:    c = PURPPLE_UNUSED_GUARD;
      4'd7:    c = BLACK;
      4'd8:    c = WHITE;
      4'd9:    c = GRAY;
      default: c = BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Pixel request bus between the timing controller (master) and the pixel
// source (slave): coordinates go out, RGB565 data returns one clock later.
interface vga_timing_ctrl_if;
  import vga_pkg::*;

  logic [9:0] pix_x;
  logic [9:0] pix_y;
  rgb565_t    pix_data;

  modport master (output pix_x, output pix_y, input pix_data);
  modport slave  (input pix_x, input pix_y, output pix_data);

endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA timing generator: horizontal/vertical counters, sync and active-video
// decode, pixel requests issued one clock early so that the pixel source's
// registered data lines up with the active-video window.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter logic [9:0] H_SYNC  = H_SYNC_DEF,
  parameter logic [9:0] H_BACK  = H_BACK_DEF,
  parameter logic [9:0] H_VALID = H_VALID_DEF,
  parameter logic [9:0] H_FRONT = H_FRONT_DEF,
  parameter logic [9:0] V_SYNC  = V_SYNC_DEF,
  parameter logic [9:0] V_BACK  = V_BACK_DEF,
  parameter logic [9:0] V_VALID = V_VALID_DEF,
  parameter logic [9:0] V_FRONT = V_FRONT_DEF
) (
  input  logic              vga_clk,
  input  logic              sys_rst_n,
  vga_timing_ctrl_if.master pix_bus,
  output logic              hsync,
  output logic              vsync,
  output logic              rgb_valid,
  output rgb565_t           rgb,
  output logic              frame_start,
  output logic [7:0]        frame_cnt
);

  localparam logic [9:0] H_TOTAL   = 10'(H_SYNC + H_BACK + H_VALID + H_FRONT);
  localparam logic [9:0] V_TOTAL   = 10'(V_SYNC + V_BACK + V_VALID + V_FRONT);
  localparam logic [9:0] H_ACT_BEG = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_ACT_END = 10'(H_ACT_BEG + H_VALID - 10'd1);
  localparam logic [9:0] V_ACT_BEG = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_ACT_END = 10'(V_ACT_BEG + V_VALID - 10'd1);
  // Requests lead the active window by one clock
  localparam logic [9:0] H_REQ_BEG = 10'(H_ACT_BEG - 10'd1);
  localparam logic [9:0] H_REQ_END = 10'(H_ACT_END - 10'd1);

  logic [9:0] cnt_h;
  logic [9:0] cnt_v;
  logic       h_end;
  logic       v_end;
  logic       h_act;
  logic       v_act;
  logic       h_req;
  logic       pix_data_req;

  // Line and frame end detection drives both counter wraps and frame_start
  always_comb begin
    h_end = (cnt_h == H_TOTAL - 10'd1);
    v_end = (cnt_v == V_TOTAL - 10'd1);
  end

  // Horizontal counter: one count per pixel clock
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h <= 10'd0;
    end else if (h_end) begin
      cnt_h <= 10'd0;
    end else begin
      cnt_h <= cnt_h + 10'd1;
    end
  end

  // Vertical counter: one count per line, wraps together with cnt_h
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_v <= 10'd0;
    end else if (h_end) begin
      if (v_end) begin
        cnt_v <= 10'd0;
      end else begin
        cnt_v <= cnt_v + 10'd1;
      end
    end
  end

  // Frame bookkeeping: pulse and count on the clock after the last pixel
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_start <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      frame_start <= h_end && v_end;
      if (h_end && v_end) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // Sync and window decode straight off the counters (no added latency)
  always_comb begin
    hsync        = (cnt_h < H_SYNC);
    vsync        = (cnt_v < V_SYNC);
    h_act        = (cnt_h >= H_ACT_BEG) && (cnt_h <= H_ACT_END);
    v_act        = (cnt_v >= V_ACT_BEG) && (cnt_v <= V_ACT_END);
    h_req        = (cnt_h >= H_REQ_BEG) && (cnt_h <= H_REQ_END);
    rgb_valid    = h_act && v_act;
    pix_data_req = h_req && v_act;
  end

  // Pixel coordinates requested from the source; idle code outside the window
  always_comb begin
    pix_bus.pix_x = PIX_IDLE;
    pix_bus.pix_y = PIX_IDLE;
    if (pix_data_req) begin
      pix_bus.pix_x = cnt_h - H_REQ_BEG;
      pix_bus.pix_y = cnt_v - V_ACT_BEG;
    end
  end

  // Blank the encoder output outside active video
  always_comb begin
    rgb = BLACK;
    if (rgb_valid) begin
      rgb = pix_bus.pix_data;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench: a default-timing instance with a colour-bar source for
// sync/alignment/line-edge checks, and a tiny-timing instance (10x6 clocks
// per frame) for frame period, frame counter wrap and mid-frame reset.
module tb_vga_timing_ctrl;
  import vga_pkg::*;

  typedef struct {
    int         pos;
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] px;
    logic [9:0] py;
    logic [15:0] rgb;
    logic       fs;
    logic [7:0] fc;
  } vec_t;

  logic        vga_clk;
  logic        rst_a;
  logic        rst_b;
  logic        hs_a, vs_a, de_a, fs_a;
  logic        hs_b, vs_b, de_b, fs_b;
  logic [15:0] rgb_a, rgb_b;
  logic [7:0]  fc_a, fc_b;

  int n_vec = 0;
  int n_err = 0;
  int pos   = 0;

  vga_timing_ctrl_if bus_a ();
  vga_timing_ctrl_if bus_b ();

  vga_timing_ctrl dut_a (
    .vga_clk     (vga_clk),
    .sys_rst_n   (rst_a),
    .pix_bus     (bus_a.master),
    .hsync       (hs_a),
    .vsync       (vs_a),
    .rgb_valid   (de_a),
    .rgb         (rgb_a),
    .frame_start (fs_a),
    .frame_cnt   (fc_a)
  );

  vga_timing_ctrl #(
    .H_SYNC (10'd2), .H_BACK (10'd2), .H_VALID (10'd4), .H_FRONT (10'd2),
    .V_SYNC (10'd1), .V_BACK (10'd1), .V_VALID (10'd3), .V_FRONT (10'd1)
  ) dut_b (
    .vga_clk     (vga_clk),
    .sys_rst_n   (rst_b),
    .pix_bus     (bus_b.master),
    .hsync       (hs_b),
    .vsync       (vs_b),
    .rgb_valid   (de_b),
    .rgb         (rgb_b),
    .frame_start (fs_b),
    .frame_cnt   (fc_b)
  );

  initial begin
    vga_clk = 1'b0;
    forever #5 vga_clk = ~vga_clk;
  end

  // Pixel sources: registered one clock after the request
  always_ff @(posedge vga_clk) bus_a.pix_data <= colour_bar(bus_a.pix_x);
  always_ff @(posedge vga_clk) bus_b.pix_data <= {bus_b.pix_y[5:0], bus_b.pix_x};

  function automatic vec_t mk(input int p, input logic hs, input logic vs,
                              input logic de, input logic [9:0] px,
                              input logic [9:0] py, input logic [15:0] c,
                              input logic fs, input logic [7:0] fc);
    vec_t v;
    v.pos = p; v.hs = hs; v.vs = vs; v.de = de; v.px = px; v.py = py;
    v.rgb = c; v.fs = fs; v.fc = fc;
    return v;
  endfunction

  function automatic vec_t sample_a();
    return mk(pos, hs_a, vs_a, de_a, bus_a.pix_x, bus_a.pix_y, rgb_a, fs_a, fc_a);
  endfunction

  function automatic vec_t sample_b();
    return mk(pos, hs_b, vs_b, de_b, bus_b.pix_x, bus_b.pix_y, rgb_b, fs_b, fc_b);
  endfunction

  task automatic cmp(input string name, input vec_t a, input vec_t e);
    n_vec++;
    if (a.hs !== e.hs || a.vs !== e.vs || a.de !== e.de || a.px !== e.px ||
        a.py !== e.py || a.rgb !== e.rgb || a.fs !== e.fs || a.fc !== e.fc) begin
      n_err++;
      $display("FAIL %s: got hs=%b vs=%b de=%b x=%h y=%h rgb=%h fs=%b fc=%0d; want hs=%b vs=%b de=%b x=%h y=%h rgb=%h fs=%b fc=%0d",
               name, a.hs, a.vs, a.de, a.px, a.py, a.rgb, a.fs, a.fc,
               e.hs, e.vs, e.de, e.px, e.py, e.rgb, e.fs, e.fc);
    end
  endtask

  // Advance n clocks; sample point sits 1 time unit after the falling edge
  task automatic adv(input int n);
    if (n > 0) begin
      repeat (n) @(negedge vga_clk);
      #1;
      pos += n;
    end
  endtask

  vec_t tbl[17];
  vec_t rst_v;

  initial begin
    int gap;

    rst_v = mk(0, 1'b1, 1'b1, 1'b0, 10'h3FF, 10'h3FF, 16'h0000, 1'b0, 8'd0);

    // pos = clocks since reset release = cnt_v*800 + cnt_h
    tbl[0]  = mk(0,     1, 1, 0, 10'h3FF, 10'h3FF, 16'h0000, 0, 0);
    tbl[1]  = mk(95,    1, 1, 0, 10'h3FF, 10'h3FF, 16'h0000, 0, 0);
    tbl[2]  = mk(96,    0, 1, 0, 10'h3FF, 10'h3FF, 16'h0000, 0, 0);
    tbl[3]  = mk(1599,  0, 1, 0, 10'h3FF, 10'h3FF, 16'h0000, 0, 0);
    tbl[4]  = mk(1600,  1, 0, 0, 10'h3FF, 10'h3FF, 16'h0000, 0, 0);
    tbl[5]  = mk(28142, 0, 0, 0, 10'h3FF, 10'h3FF, 16'h0000, 0, 0);
    tbl[6]  = mk(28143, 0, 0, 0, 10'd0,   10'd0,   16'h0000, 0, 0);
    tbl[7]  = mk(28144, 0, 0, 1, 10'd1,   10'd0,   16'hF800, 0, 0);
    tbl[8]  = mk(28207, 0, 0, 1, 10'd64,  10'd0,   16'hF800, 0, 0);
    tbl[9]  = mk(28208, 0, 0, 1, 10'd65,  10'd0,   16'hFC00, 0, 0);
    tbl[10] = mk(28271, 0, 0, 1, 10'd128, 10'd0,   16'hFC00, 0, 0);
    tbl[11] = mk(28720, 0, 0, 1, 10'd577, 10'd0,   16'hD69A, 0, 0);
    tbl[12] = mk(28782, 0, 0, 1, 10'd639, 10'd0,   16'hD69A, 0, 0);
    tbl[13] = mk(28783, 0, 0, 1, 10'h3FF, 10'h3FF, 16'hD69A, 0, 0);
    tbl[14] = mk(28784, 0, 0, 0, 10'h3FF, 10'h3FF, 16'h0000, 0, 0);
    tbl[15] = mk(28943, 0, 0, 0, 10'd0,   10'd1,   16'h0000, 0, 0);
    tbl[16] = mk(29200, 0, 0, 1, 10'd257, 10'd1,   16'h07FF, 0, 0);

    rst_a = 1'b0;
    rst_b = 1'b0;
    #12;
    cmp("reset_a", sample_a(), rst_v);
    cmp("reset_b", sample_b(), rst_v);

    // Default-timing instance: table sweep
    @(negedge vga_clk);
    rst_a = 1'b1;
    #1;
    pos = 0;
    for (int i = 0; i < 17; i++) begin
      adv(tbl[i].pos - pos);
      cmp($sformatf("vec%0d_pos%0d", i, tbl[i].pos), sample_a(), tbl[i]);
    end

    // Reset in the middle of an active line
    #2;
    rst_a = 1'b0;
    #1;
    cmp("a_midreset_now", sample_a(), rst_v);
    adv(3);
    cmp("a_midreset_hold", sample_a(), rst_v);
    @(negedge vga_clk);
    rst_a = 1'b1;
    #1;
    pos = 0;
    cmp("a_restart_0", sample_a(), rst_v);
    adv(95);
    cmp("a_restart_95", sample_a(), mk(95, 1, 1, 0, 10'h3FF, 10'h3FF, 16'h0000, 0, 0));
    adv(1);
    cmp("a_restart_96", sample_a(), mk(96, 0, 1, 0, 10'h3FF, 10'h3FF, 16'h0000, 0, 0));

    // Tiny-timing instance: 60-clock frames, counter wrap after 256 frames
    @(negedge vga_clk);
    rst_b = 1'b1;
    #1;
    pos = 0;
    for (int k = 1; k <= 257; k++) begin
      gap = 0;
      do begin
        adv(1);
        gap++;
      end while (fs_b !== 1'b1 && gap < 70);
      n_vec++;
      if (fs_b !== 1'b1 || gap != 60 || fc_b !== 8'(k)) begin
        n_err++;
        $display("FAIL frame%0d: got fs=%b gap=%0d fc=%0d; want fs=1 gap=60 fc=%0d",
                 k, fs_b, gap, fc_b, k % 256);
      end
    end
    adv(1);
    cmp("b_pulse_end", sample_b(), mk(0, 1, 1, 0, 10'h3FF, 10'h3FF, 16'h0000, 0, 8'd1));
    adv(34);
    cmp("b_active", sample_b(), mk(0, 0, 0, 1, 10'd2, 10'd1, 16'h0401, 0, 8'd1));

    // Reset mid-frame on the tiny instance
    #2;
    rst_b = 1'b0;
    #1;
    cmp("b_midreset_now", sample_b(), rst_v);
    adv(2);
    cmp("b_midreset_hold", sample_b(), rst_v);
    @(negedge vga_clk);
    rst_b = 1'b1;
    #1;
    pos = 0;
    cmp("b_restart_0", sample_b(), rst_v);
    adv(2);
    cmp("b_restart_2", sample_b(), mk(2, 0, 1, 0, 10'h3FF, 10'h3FF, 16'h0000, 0, 0));
    adv(8);
    cmp("b_restart_10", sample_b(), mk(10, 1, 0, 0, 10'h3FF, 10'h3FF, 16'h0000, 0, 0));
    adv(49);
    cmp("b_restart_59", sample_b(), mk(59, 0, 0, 0, 10'h3FF, 10'h3FF, 16'h0000, 0, 0));
    adv(1);
    cmp("b_restart_60", sample_b(), mk(60, 1, 1, 0, 10'h3FF, 10'h3FF, 16'h0000, 1, 8'd1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 SHALL have parameter H_SYNC, default 10'd96, hsync pulse width in clocks.
REQ-002 SHALL have parameter H_BACK, default 10'd48, horizontal back porch.
REQ-003 SHALL have parameter H_VALID, default 10'd640, active pixels per line.
REQ-004 SHALL have parameter H_FRONT, default 10'd16, horizontal front porch; H_TOTAL = sum = 800.
REQ-005 SHALL have parameter V_SYNC, default 10'd2, vsync pulse width in lines.
REQ-006 SHALL have parameter V_BACK, default 10'd33, vertical back porch.
REQ-007 SHALL have parameter V_VALID, default 10'd480, active lines.
REQ-008 SHALL have parameter V_FRONT, default 10'd10, vertical front porch; V_TOTAL = sum = 525.
REQ-009 SHALL have port vga_clk  input  1  pixel clock (25 MHz nominal).
REQ-010 SHALL have port sys_rst_n  input  1  asynchronous, active-low reset.
REQ-011 SHALL have port pix_data  input  16  RGB565 pixel returned by the pixel source, registered one clock after pix_x/pix_y.
REQ-012 SHALL have port pix_x  output  10  requested column, 0..H_VALID-1, else 10'h3FF.
REQ-013 SHALL have port pix_y  output  10  requested row, 0..V_VALID-1, else 10'h3FF.
REQ-014 SHALL have port hsync  output  1  horizontal sync, active high.
REQ-015 SHALL have port vsync  output  1  vertical sync, active high.
REQ-016 SHALL have port rgb_valid  output  1  active-video window (DE).
REQ-017 SHALL have port rgb  output  16  pixel to encoder: pix_data when rgb_valid, else 16'h0000.
REQ-018 SHALL have port frame_start  output  1  one-clock pulse at start of each frame.
REQ-019 SHALL have port frame_cnt  output  8  frame counter, wraps 255->0.

Function
REQ-020 SHALL count cnt_h 0..H_TOTAL-1, incrementing every clock, wrapping to 0 after H_TOTAL-1.
REQ-021 SHALL count cnt_v 0..V_TOTAL-1, incrementing only when cnt_h==H_TOTAL-1, wrapping to 0 after V_TOTAL-1 in the same clock cnt_h wraps.
REQ-022 SHALL drive hsync=1 iff cnt_h<H_SYNC and vsync=1 iff cnt_v<V_SYNC (decode of registered counters, no extra latency).
REQ-023 SHALL drive rgb_valid=1 iff cnt_h in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VALID-1] (144..783) and cnt_v in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VALID-1] (35..514).
REQ-024 SHALL assert internal pix_data_req one clock ahead of rgb_valid: cnt_h in 143..782, same cnt_v window.
REQ-025 SHALL drive pix_x=cnt_h-143 and pix_y=cnt_v-35 while pix_data_req, else both 10'h3FF, so the one-clock-registered pix_data aligns with rgb_valid.
REQ-026 SHALL pass rgb=pix_data combinationally when rgb_valid, else 16'h0000.
REQ-027 SHALL register frame_start=1 for exactly the clock following cnt_h==H_TOTAL-1 && cnt_v==V_TOTAL-1, and increment frame_cnt in that same clock.
REQ-028 SHALL be frame-exact: 420000 clocks between consecutive frame_start pulses with default parameters.

Reset
REQ-029 SHALL on sys_rst_n low clear cnt_h, cnt_v, frame_cnt and frame_start to 0 asynchronously, regardless of position in frame.
REQ-030 SHALL while in reset present hsync=1, vsync=1, rgb_valid=0, rgb=16'h0000, pix_x=pix_y=10'h3FF.
REQ-031 SHALL after reset release restart from cnt_h=0, cnt_v=0 with no frame_start pulse until the first full frame completes.

Structure
REQ-032 SHALL place timing parameters and the RGB565 colour constants in a shared vga_pkg used by this block and the pixel source.
REQ-033 SHALL be a single module; no sub-modules required.

Verification
REQ-034 SHALL verify reset release: first 96 clocks hsync=1, clock 96 hsync=0; vsync=1 for first 1600 clocks, 0 from clock 1600.
REQ-035 SHALL verify request alignment: at cnt_v=35, cnt_h=143 -> pix_x=0, pix_y=0; next clock rgb_valid=1 and rgb equals stub's registered value for (0,0).
REQ-036 SHALL verify line edge: cnt_h=782 -> pix_x=639; cnt_h=783 -> pix_x=10'h3FF, rgb_valid=1; cnt_h=784 -> rgb_valid=0, rgb=0.
REQ-037 SHALL verify with colour-bar stub: line 0 pixels 0..63 = 16'hF800, 64..127 = 16'hFC00, 576..639 = 16'hD69A.
REQ-038 SHALL verify wrap: frame_start pulses every 420000 clocks, frame_cnt 255->0 after 256 frames.
REQ-039 SHALL verify mid-frame reset at cnt_v=200, cnt_h=400: outputs reach reset values immediately; after release, timing restarts from cnt_h=0, cnt_v=0.
